// File: rtl/legv8_instr_encoder_if.sv
// Request/stream bundle for the LEGv8 instruction encoder.
// master = producer/consumer side (bench, debug port); slave = encoder.
interface legv8_instr_encoder_if #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 32
);
   localparam int unsigned LevelW = $clog2(DEPTH) + 1;

   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_op;
   logic [4:0]        in_rd;
   logic [4:0]        in_rn;
   logic [4:0]        in_rm;
   logic [25:0]       in_imm;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_addr;
   logic              err_illegal;
   logic [LevelW-1:0] level;

   modport master (
      output flush, in_valid, in_op, in_rd, in_rn, in_rm, in_imm, out_ready,
      input  in_ready, out_valid, out_instr, out_addr, err_illegal, level
   );

   modport slave (
      input  flush, in_valid, in_op, in_rd, in_rn, in_rm, in_imm, out_ready,
      output in_ready, out_valid, out_instr, out_addr, err_illegal, level
   );
endinterface

// File: rtl/legv8_instr_encoder.sv
// Builds 32-bit LEGv8 words (R/D/CB/B) from symbolic requests and streams them out of a FIFO
// with incrementing byte addresses. Define IMM_RANGE_CHECK_EN to reject out-of-range immediates.
module legv8_instr_encoder #(
   parameter int unsigned       DEPTH     = 4,
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input logic                  clk,
   input logic                  rst_n,
   legv8_instr_encoder_if.slave bus
);
   localparam int unsigned PtrW   = $clog2(DEPTH);
   localparam int unsigned LevelW = PtrW + 1;

   typedef enum logic [3:0] {
      OpLdur = 4'd0,
      OpStur = 4'd1,
      OpCbz  = 4'd2,
      OpAdd  = 4'd3,
      OpSub  = 4'd4,
      OpAnd  = 4'd5,
      OpOrr  = 4'd6,
      OpLsl  = 4'd7,
      OpLsr  = 4'd8,
      OpB    = 4'd9
   } op_e;

   logic [31:0] enc_word;
   logic        enc_legal;
   op_e         op;

   assign op = op_e'(bus.in_op);

   always_comb begin
      enc_word  = '0;
      enc_legal = 1'b1;
      case (op)
         OpLdur: enc_word = {11'b11111000010, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rd};
         OpStur: enc_word = {11'b11111000000, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rd};
         OpCbz:  enc_word = {8'b10110100, bus.in_imm[18:0], bus.in_rd};
         OpAdd:  enc_word = {11'b10001011000, bus.in_rm, 6'b0, bus.in_rn, bus.in_rd};
         OpSub:  enc_word = {11'b11001011000, bus.in_rm, 6'b0, bus.in_rn, bus.in_rd};
         OpAnd:  enc_word = {11'b10001010000, bus.in_rm, 6'b0, bus.in_rn, bus.in_rd};
         OpOrr:  enc_word = {11'b10101010000, bus.in_rm, 6'b0, bus.in_rn, bus.in_rd};
         OpLsl:  enc_word = {11'b11010011011, 5'b0, bus.in_imm[5:0], bus.in_rn, bus.in_rd};
         OpLsr:  enc_word = {11'b11010011010, 5'b0, bus.in_imm[5:0], bus.in_rn, bus.in_rd};
         OpB:    enc_word = {6'b000101, bus.in_imm};
         default: enc_legal = 1'b0;
      endcase
`ifdef IMM_RANGE_CHECK_EN
      // Any immediate bit above the field the op consumes makes the request illegal.
      case (op)
         OpAdd, OpSub, OpAnd, OpOrr: if (bus.in_imm != '0)        enc_legal = 1'b0;
         OpLsl, OpLsr:               if (bus.in_imm[25:6] != '0)  enc_legal = 1'b0;
         OpLdur, OpStur:             if (bus.in_imm[25:9] != '0)  enc_legal = 1'b0;
         OpCbz:                      if (bus.in_imm[25:19] != '0) enc_legal = 1'b0;
         default: ;
      endcase
`endif
   end

   logic [31:0]       mem_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LevelW-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              err_q, err_d;
   logic              full, empty, accept, push, pop;

   assign full   = (cnt_q == LevelW'(DEPTH));
   assign empty  = (cnt_q == '0);
   // No pass-through when full: a same-cycle pop does not open in_ready.
   assign bus.in_ready = rst_n & ~full & ~bus.flush;
   assign accept = bus.in_valid & bus.in_ready;
   assign push   = accept & enc_legal;
   assign pop    = ~empty & bus.out_ready & ~bus.flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      err_d    = 1'b0;
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         addr_d   = BASE_ADDR;
      end else begin
         err_d = accept & ~enc_legal;
         if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            addr_d   = addr_q + ADDR_W'(4);
         end
         if (push && !pop)      cnt_d = cnt_q + LevelW'(1);
         else if (pop && !push) cnt_d = cnt_q - LevelW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         addr_q   <= BASE_ADDR;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         err_q    <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= enc_word;
   end

   assign bus.out_valid   = ~empty;
   assign bus.out_instr   = empty ? 32'h0 : mem_q[rd_ptr_q];
   assign bus.out_addr    = addr_q;
   assign bus.err_illegal = err_q;
   assign bus.level       = cnt_q;
endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Self-checking bench for legv8_instr_encoder: directed scenarios plus a randomized run
// scored against a queue-based reference model.
module tb_legv8_instr_encoder;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned ADDR_W = 32;
   localparam logic [31:0] BASE   = 32'h0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   legv8_instr_encoder_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

   legv8_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // 11-bit opcodes indexed by op number (CBZ and B use their own prefixes)
   int unsigned opc_tab [10] = '{'h7C2, 'h7C0, 0, 'h458, 'h658, 'h450, 'h550, 'h69B, 'h69A, 0};

   function automatic bit ref_legal(input int unsigned op, input int unsigned imm);
      if (op > 9) return 1'b0;
`ifdef IMM_RANGE_CHECK_EN
      case (op)
         3, 4, 5, 6: return imm == 0;
         7, 8:       return imm < 64;
         0, 1:       return imm < 512;
         2:          return imm < 524288;
         default:    return 1'b1;
      endcase
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [31:0] ref_word(input int unsigned op, input int unsigned rd,
                                            input int unsigned rn, input int unsigned rm,
                                            input int unsigned imm);
      longint unsigned w;
      longint unsigned opc;
      opc = longint'(opc_tab[op]);
      case (op)
         0, 1:       w = opc * 2097152 + (imm % 512) * 4096 + rn * 32 + rd;
         2:          w = 64'hB4 * 16777216 + (imm % 524288) * 32 + rd;
         3, 4, 5, 6: w = opc * 2097152 + rm * 65536 + rn * 32 + rd;
         7, 8:       w = opc * 2097152 + (imm % 64) * 1024 + rn * 32 + rd;
         default:    w = 5 * 67108864 + (imm % 67108864);
      endcase
      return w[31:0];
   endfunction

   task automatic set_req(input int unsigned op, input int unsigned rd, input int unsigned rn,
                          input int unsigned rm, input int unsigned imm);
      bus.in_valid = 1'b1;
      bus.in_op    = op[3:0];
      bus.in_rd    = rd[4:0];
      bus.in_rn    = rn[4:0];
      bus.in_rm    = rm[4:0];
      bus.in_imm   = imm[25:0];
   endtask

   task automatic idle_req();
      bus.in_valid = 1'b0;
   endtask

   task automatic do_flush();
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.level !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_flags got rdy=%b vld=%b lvl=%0d exp 0/0/0",
                  bus.in_ready, bus.out_valid, bus.level);
      end
      n_checks++;
      if (bus.out_instr !== 32'h0 || bus.out_addr !== BASE || bus.err_illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_data got instr=%h addr=%h err=%b exp 0/%h/0",
                  bus.out_instr, bus.out_addr, bus.err_illegal, BASE);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready got %b exp 1", bus.in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      set_req(3, 1, 2, 3, 0);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL add_no_fallthrough got vld=%b exp 0", bus.out_valid);
      end
      @(posedge clk); #1;
      idle_req();
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h8B030041 || bus.out_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL add_word got vld=%b instr=%h addr=%h exp 1/8b030041/0",
                  bus.out_valid, bus.out_instr, bus.out_addr);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.level !== 3'd0 || bus.out_addr !== 32'h4) begin
         n_fail++;
         $display("FAIL add_pop got vld=%b lvl=%0d addr=%h exp 0/0/4",
                  bus.out_valid, bus.level, bus.out_addr);
      end
   endtask

   task automatic test_back_to_back();
      do_flush();
      bus.out_ready = 1'b1;
      set_req(0, 9, 10, 0, 8);
      @(posedge clk); #1;
      set_req(2, 5, 0, 0, 16);
      @(negedge clk);
      n_checks++;
      if (bus.out_instr !== 32'hF8408149 || bus.out_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL b2b_ldur got instr=%h addr=%h exp f8408149/0", bus.out_instr, bus.out_addr);
      end
      @(posedge clk); #1;
      idle_req();
      @(negedge clk);
      n_checks++;
      if (bus.out_instr !== 32'hB4000205 || bus.out_addr !== 32'h4 || bus.level !== 3'd1) begin
         n_fail++;
         $display("FAIL b2b_cbz got instr=%h addr=%h lvl=%0d exp b4000205/4/1",
                  bus.out_instr, bus.out_addr, bus.level);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.out_addr !== 32'h8) begin
         n_fail++;
         $display("FAIL b2b_drain got vld=%b addr=%h exp 0/8", bus.out_valid, bus.out_addr);
      end
   endtask

   task automatic test_full();
      do_flush();
      bus.out_ready = 1'b0;
      set_req(7, 1, 2, 0, 4);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         n_checks++;
         if (bus.level !== 3'(i)) begin
            n_fail++;
            $display("FAIL full_level got %0d exp %0d", bus.level, i);
         end
      end
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_instr !== 32'hD3601041) begin
         n_fail++;
         $display("FAIL full_stall got rdy=%b instr=%h exp 0/d3601041",
                  bus.in_ready, bus.out_instr);
      end
      bus.out_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_no_passthru got rdy=%b exp 0", bus.in_ready);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      idle_req();
      @(negedge clk);
      n_checks++;
      if (bus.level !== 3'd3 || bus.in_ready !== 1'b1 || bus.out_addr !== 32'h4) begin
         n_fail++;
         $display("FAIL full_pop got lvl=%0d rdy=%b addr=%h exp 3/1/4",
                  bus.level, bus.in_ready, bus.out_addr);
      end
   endtask

   task automatic test_illegal();
      do_flush();
      set_req(12, 1, 1, 1, 0);
      @(posedge clk); #1;
      set_req(9, 0, 0, 0, 3);
      @(negedge clk);
      n_checks++;
      if (bus.err_illegal !== 1'b1 || bus.level !== 3'd0 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_drop got err=%b lvl=%0d vld=%b exp 1/0/0",
                  bus.err_illegal, bus.level, bus.out_valid);
      end
      @(posedge clk); #1;
      idle_req();
      @(negedge clk);
      n_checks++;
      if (bus.err_illegal !== 1'b0 || bus.level !== 3'd1 || bus.out_instr !== 32'h14000003 ||
          bus.out_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL illegal_then_b got err=%b lvl=%0d instr=%h addr=%h exp 0/1/14000003/0",
                  bus.err_illegal, bus.level, bus.out_instr, bus.out_addr);
      end
   endtask

   task automatic test_flush();
      do_flush();
      set_req(3, 1, 2, 3, 0);
      @(posedge clk); #1;
      set_req(3, 4, 5, 6, 0);
      @(posedge clk); #1;
      idle_req();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.level !== 3'd1 || bus.out_addr !== 32'h4 || bus.out_instr !== 32'h8B0600A4) begin
         n_fail++;
         $display("FAIL flush_pre got lvl=%0d addr=%h instr=%h exp 1/4/8b0600a4",
                  bus.level, bus.out_addr, bus.out_instr);
      end
      bus.flush     = 1'b1;
      bus.out_ready = 1'b1;
      set_req(3, 1, 1, 1, 0);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_ready got %b exp 0", bus.in_ready);
      end
      @(posedge clk); #1;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      idle_req();
      @(negedge clk);
      n_checks++;
      if (bus.level !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_addr !== BASE) begin
         n_fail++;
         $display("FAIL flush_clear got lvl=%0d vld=%b addr=%h exp 0/0/%h",
                  bus.level, bus.out_valid, bus.out_addr, BASE);
      end
      set_req(3, 7, 8, 9, 0);
      @(posedge clk); #1;
      idle_req();
      @(negedge clk);
      n_checks++;
      if (bus.out_instr !== 32'h8B090107 || bus.out_addr !== BASE) begin
         n_fail++;
         $display("FAIL flush_next got instr=%h addr=%h exp 8b090107/%h",
                  bus.out_instr, bus.out_addr, BASE);
      end
   endtask

   task automatic test_imm_range();
      do_flush();
      set_req(7, 1, 2, 0, 'h40);
      @(posedge clk); #1;
      idle_req();
      @(negedge clk);
      n_checks++;
`ifdef IMM_RANGE_CHECK_EN
      if (bus.err_illegal !== 1'b1 || bus.level !== 3'd0) begin
         n_fail++;
         $display("FAIL imm_range got err=%b lvl=%0d exp 1/0", bus.err_illegal, bus.level);
      end
`else
      if (bus.err_illegal !== 1'b0 || bus.level !== 3'd1 || bus.out_instr !== 32'hD3600041) begin
         n_fail++;
         $display("FAIL imm_trunc got err=%b lvl=%0d instr=%h exp 0/1/d3600041",
                  bus.err_illegal, bus.level, bus.out_instr);
      end
`endif
   endtask

   task automatic test_random();
      logic [31:0] q[$];
      logic [31:0] exp_addr;
      logic        exp_err;
      logic        exp_ready, acc, pop, legal;
      int unsigned op, rd, rn, rm, imm;
      do_flush();
      exp_addr = BASE;
      exp_err  = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         op  = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
         rd  = $urandom_range(0, 31);
         rn  = $urandom_range(0, 31);
         rm  = $urandom_range(0, 31);
         imm = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h3FFFFFF) : $urandom_range(0, 70);
         if ($urandom_range(0, 2) == 0 && op >= 3 && op <= 6) imm = 0;
         set_req(op, rd, rn, rm, imm);
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         bus.flush     = ($urandom_range(0, 49) == 0);
         @(negedge clk);
         exp_ready = (q.size() < DEPTH) && !bus.flush;
         n_checks++;
         if (bus.in_ready !== exp_ready || bus.out_valid !== (q.size() != 0) ||
             bus.level !== 3'(q.size()) || bus.err_illegal !== exp_err) begin
            n_fail++;
            $display("FAIL rand_ctl cyc %0d got rdy=%b vld=%b lvl=%0d err=%b exp %b/%b/%0d/%b",
                     cyc, bus.in_ready, bus.out_valid, bus.level, bus.err_illegal,
                     exp_ready, q.size() != 0, q.size(), exp_err);
         end
         if (q.size() != 0) begin
            n_checks++;
            if (bus.out_instr !== q[0] || bus.out_addr !== exp_addr) begin
               n_fail++;
               $display("FAIL rand_data cyc %0d got instr=%h addr=%h exp %h/%h",
                        cyc, bus.out_instr, bus.out_addr, q[0], exp_addr);
            end
         end
         acc   = bus.in_valid && exp_ready;
         pop   = (q.size() != 0) && bus.out_ready && !bus.flush;
         legal = ref_legal(op, imm);
         if (bus.flush) begin
            q.delete();
            exp_addr = BASE;
            exp_err  = 1'b0;
         end else begin
            exp_err = acc && !legal;
            if (pop) begin
               void'(q.pop_front());
               exp_addr = exp_addr + 32'd4;
            end
            if (acc && legal) q.push_back(ref_word(op, rd, rn, rm, imm));
         end
         @(posedge clk); #1;
      end
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      idle_req();
   endtask

   initial begin
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_op     = '0;
      bus.in_rd     = '0;
      bus.in_rn     = '0;
      bus.in_rm     = '0;
      bus.in_imm    = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_add();
      test_back_to_back();
      test_full();
      test_illegal();
      test_flush();
      test_imm_range();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog expired");
   end
endmodule
